// File: rtl/mem_1024x8_dp_access_ctrl.sv
// mem_1024x8_dp_access_ctrl: valid/ready front end, zero-fill and credit-limited response FIFO for a dual-port RAM
module mem_1024x8_dp_access_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t START = CLEAR_ON_RESET != 0 ? CLEAR : RUN;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [CW-1:0] inflight, count;
    logic [CW:0] used;
    logic [PW-1:0] wptr, rptr;
    logic [DATA_W-1:0] fifo [RSP_DEPTH];
    logic [RD_LATENCY-1:0] vld, byp;
    logic [DATA_W-1:0] bdat [RD_LATENCY];
    logic wr_fire, rd_fire, push, pop, hit;
    logic [DATA_W-1:0] push_data;

    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = vld[RD_LATENCY-1];
    assign push_data = byp[RD_LATENCY-1] ? bdat[RD_LATENCY-1] : mem_data_out;
    assign hit       = mem_wen && mem_ren && mem_waddr == mem_raddr;
    assign rsp_valid = count != '0;
    assign rsp_data  = rsp_valid ? fifo[rptr] : '0;

    // State register
    always_ff @(posedge clk)
        state <= reset ? START : state_nxt;

    // Leave CLEAR once the last address is issued; credits count a same-cycle pop as free
    always_comb begin
        state_nxt = (state == CLEAR && clr_cnt == '1) ? RUN : state;
        used      = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
        wr_ready  = init_done;
        rd_ready  = init_done && used < DEPTH;
    end

    // Clear address counter; init_done trails the last clear write by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            clr_cnt   <= state == CLEAR ? clr_cnt + ADDR_W'(1) : clr_cnt;
            init_done <= state == RUN;
        end
    end

    // Registered memory port strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            mem_waddr   <= '0;
            mem_raddr   <= '0;
            mem_data_in <= '0;
        end else if (state == CLEAR) begin
            mem_wen     <= 1'b1;
            mem_ren     <= 1'b0;
            mem_waddr   <= clr_cnt;
            mem_data_in <= '0;
        end else begin
            mem_wen <= wr_fire;
            mem_ren <= rd_fire;
            if (wr_fire) begin
                mem_waddr   <= wr_addr;
                mem_data_in <= wr_data;
            end
            if (rd_fire) mem_raddr <= rd_addr;
        end
    end

    // Read-valid and collision-flag pipes, aligned with the memory read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            byp <= '0;
        end else begin
            vld[0] <= mem_ren;
            byp[0] <= hit;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                byp[i] <= byp[i-1];
            end
        end
    end

    // Write data carried alongside a colliding read
    always_ff @(posedge clk) begin
        bdat[0] <= mem_data_in;
        for (int i = 1; i < RD_LATENCY; i++) bdat[i] <= bdat[i-1];
    end

    // Outstanding-read and FIFO occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            inflight <= inflight + CW'(rd_fire) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
            if (push) wptr <= wptr == LAST ? '0 : wptr + PW'(1);
            if (pop) rptr <= rptr == LAST ? '0 : rptr + PW'(1);
        end
    end

    // Response storage
    always_ff @(posedge clk)
        if (push) fifo[wptr] <= push_data;

    assert property (@(posedge clk) disable iff (reset) !(push && !pop && count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_mem_1024x8_dp_access_ctrl.sv
// tb_mem_1024x8_dp_access_ctrl: directed checks of clear, read/write timing, collision bypass, credits and reset
module tb_mem_1024x8_dp_access_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready, init_done, mem_wen, mem_ren;
    logic [9:0] wr_addr, rd_addr, mem_waddr, mem_raddr;
    logic [7:0] wr_data, rsp_data, mem_data_in, mem_data_out;
    logic [7:0] mem [1024];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_1024x8_dp_access_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_data_in(mem_data_in),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_data_out(mem_data_out)
    );

    // Read-before-write RAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem[mem_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {22'b0, wr_ready, rd_ready, rsp_valid, rsp_data, init_done,
                mem_waddr, mem_raddr, mem_data_in, mem_wen, mem_ren};
    endfunction

    initial begin
        int k, got, n;
        logic rv, acc;
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        mem_data_out = 8'h00;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b1;
        tick;
        tick;
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tick;
            check("clear_seq", 64'({mem_wen, mem_ren, wr_ready, rd_ready, init_done, mem_waddr, mem_data_in}),
                  64'({5'b10000, 10'(i), 8'h00}));
        end
        tick;
        check("init_done", 64'({init_done, wr_ready, rd_ready, mem_wen}), 64'(4'b1110));

        rd_valid = 1'b1; rd_addr = 10'h3FF;
        tick;
        check("rd_issue", 64'({mem_ren, mem_raddr}), 64'({1'b1, 10'h3FF}));
        rd_valid = 1'b0;
        tick;
        check("rd_lat", 64'(rsp_valid), 64'd0);
        tick;
        check("rd_cleared_data", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'h00}));
        tick;
        check("rd_popped", 64'(rsp_valid), 64'd0);

        wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 8'hA5;
        tick;
        check("wr_issue", 64'({mem_wen, mem_waddr, mem_data_in}), 64'({1'b1, 10'h3FF, 8'hA5}));
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h3FF;
        tick;
        check("wr_pulse_end", 64'({mem_wen, mem_ren}), 64'(2'b01));
        rd_valid = 1'b0;
        tick;
        check("wr_rd_lat", 64'(rsp_valid), 64'd0);
        tick;
        check("wr_rd_data", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'hA5}));
        tick;

        wr_valid = 1'b1; wr_addr = 10'h012; wr_data = 8'h5C;
        rd_valid = 1'b1; rd_addr = 10'h012;
        tick;
        check("collide_issue", 64'({mem_wen, mem_ren, mem_waddr, mem_raddr}), 64'({2'b11, 10'h012, 10'h012}));
        wr_valid = 1'b0; rd_valid = 1'b0;
        tick;
        check("collide_lat", 64'(rsp_valid), 64'd0);
        tick;
        check("collide_bypass", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'h5C}));
        tick;

        wr_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            wr_addr = 10'(32'h100 + j);
            wr_data = 8'(32'h10 + j);
            tick;
        end
        wr_valid = 1'b0; rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'h100; k = 0;
        for (int c = 0; c < 8; c++) begin
            acc = rd_ready;
            tick;
            if (acc) begin
                k++;
                rd_addr = 10'(32'h100 + k);
            end
        end
        check("credit_accepts", 64'(k), 64'd4);
        check("credit_block", 64'(rd_ready), 64'd0);
        check("fifo_head", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'h10}));
        tick;
        check("head_stable", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'h10}));
        rsp_ready = 1'b1;
        #1;
        check("pop_credit", 64'(rd_ready), 64'd1);
        got = 0; n = 0;
        while (got < 6 && n < 40) begin
            rv = rsp_valid;
            acc = rd_valid && rd_ready;
            if (rv) check("rsp_order", 64'(rsp_data), 64'(8'(32'h10 + got)));
            tick;
            n++;
            if (rv) got++;
            if (acc) begin
                k++;
                if (k == 6) rd_valid = 1'b0;
                else rd_addr = 10'(32'h100 + k);
            end
        end
        check("rsp_count", 64'(got), 64'd6);

        reset = 1'b1;
        tick;
        check("reset_run_outputs", outs(), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 513; i++) tick;
        check("clear_at_200", 64'({mem_wen, mem_waddr}), 64'({1'b1, 10'h200}));
        reset = 1'b1;
        tick;
        check("reset_mid_clear", outs(), 64'd0);
        reset = 1'b0;
        tick;
        check("clear_restart", 64'({mem_wen, mem_waddr, init_done}), 64'({1'b1, 10'h000, 1'b0}));
        for (int i = 1; i < 1024; i++) tick;
        tick;
        check("reinit", 64'({init_done, wr_ready, rd_ready}), 64'(3'b111));

        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'h3FF;
        tick;
        tick;
        rd_valid = 1'b0; reset = 1'b1;
        tick;
        check("reset_inflight_outputs", outs(), 64'd0);
        tick;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            check("no_late_rsp", 64'(rsp_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
